// File: rtl/err_inj_pkg.sv
// Shared definitions for the error injector: corruption modes, FSM
// states and the LFSR feedback polynomials.
package err_inj_pkg;

  typedef enum logic [1:0] {
    MODE_PASS    = 2'd0,
    MODE_REPLACE = 2'd1,
    MODE_FLIP    = 2'd2,
    MODE_BURST   = 2'd3
  } corrupt_mode_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } inj_state_t;

  // Fibonacci tap masks (bit n-1 set for each x^n term of the polynomial)
  // x^8 + x^6 + x^5 + x^4 + 1
  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
  // x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
  // x^32 + x^22 + x^2 + x^1 + 1
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

  // Picks the tap mask for a supported width; other widths fall back to
  // the two top bits, which keeps the register nonzero but is not maximal.
  function automatic logic [63:0] lfsr_taps(input int width);
    case (width)
      8:       return {56'd0, LFSR_TAPS_8};
      16:      return {48'd0, LFSR_TAPS_16};
      32:      return {32'd0, LFSR_TAPS_32};
      default: return 64'd3 << (width - 2);
    endcase
  endfunction

endpackage

// File: rtl/err_injector_if.sv
// Line-side bus of the error injector: frame position, incoming word and
// the registered outgoing word.
interface err_injector_if #(
  parameter int DATA_W = 8
) ();

  logic [1:0]        i_row_cnt;
  logic [10:0]       i_col_cnt;
  logic [DATA_W-1:0] i_frame_data;
  logic              i_frame_data_valid;
  logic              i_frame_data_fas;
  logic [DATA_W-1:0] o_frame_data;
  logic              o_frame_data_valid;
  logic              o_frame_data_fas;

  modport master (
    output i_row_cnt, i_col_cnt, i_frame_data, i_frame_data_valid, i_frame_data_fas,
    input  o_frame_data, o_frame_data_valid, o_frame_data_fas
  );

  modport slave (
    input  i_row_cnt, i_col_cnt, i_frame_data, i_frame_data_valid, i_frame_data_fas,
    output o_frame_data, o_frame_data_valid, o_frame_data_fas
  );

endinterface

// File: rtl/err_lfsr.sv
// Fibonacci LFSR that supplies the pseudo-random trigger and bit-select
// values. A zero seed is replaced by 1 so the register never locks up.
module err_lfsr
  import err_inj_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] seed,
  input  logic         step,
  output logic [W-1:0] state
);

  localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

  logic feedback;

  assign feedback = ^(state & TAPS);

  // Load the seed on reset, then shift one position per enabled step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= (seed == '0) ? {{(W-1){1'b0}}, 1'b1} : seed;
    end else if (step) begin
      state <= {state[W-2:0], feedback};
    end
  end

endmodule

// File: rtl/err_injector.sv
// Frame error injector: passes the line through with one cycle of latency
// and, when enabled, corrupts eligible words by replacement, single-bit
// flip or bursts of inverted words. Row 0 overhead columns are never
// touched. Corrupted words are counted in a saturating counter.
module err_injector
  import err_inj_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int LFSR_W    = 16,
  parameter int PROT_COLS = 7
) (
  input  logic              i_clk,
  input  logic              i_rst,
  err_injector_if.slave     line,
  input  logic              i_corrupt_en,
  input  logic [1:0]        i_corrupt_mode,
  input  logic [LFSR_W-1:0] i_corrupt_seed,
  input  logic [7:0]        i_corrupt_thresh,
  input  logic [3:0]        i_burst_len,
  input  logic              i_cnt_clr,
  output logic [31:0]       o_err_cnt,
  output logic              o_burst_active
);

  localparam int BIT_W = $clog2(DATA_W);

  corrupt_mode_t     mode;
  inj_state_t        state_q, state_d;
  logic [3:0]        rem_q, rem_d;
  logic [3:0]        burst_rem_load;
  logic [LFSR_W-1:0] lfsr_q;
  logic              lfsr_step;
  logic              unused_lfsr;
  logic              is_protected;
  logic              eligible;
  logic              trigger;
  logic [BIT_W-1:0]  flip_idx;
  logic [DATA_W-1:0] flip_mask;
  logic [DATA_W-1:0] data_d, data_q;
  logic              valid_q, fas_q;
  logic              corrupt;
  logic [31:0]       err_cnt_d, err_cnt_q;

  assign mode      = corrupt_mode_t'(i_corrupt_mode);
  assign lfsr_step = i_corrupt_en & line.i_frame_data_valid;

  err_lfsr #(.W(LFSR_W)) u_lfsr (
    .clk   (i_clk),
    .rst   (i_rst),
    .seed  (i_corrupt_seed),
    .step  (lfsr_step),
    .state (lfsr_q)
  );

  // Only the low byte and the bit-select field are consumed
  assign unused_lfsr = ^lfsr_q;

  assign is_protected   = (line.i_row_cnt == 2'd0) && (line.i_col_cnt < 11'(PROT_COLS));
  assign eligible       = line.i_frame_data_valid && i_corrupt_en &&
                          (mode != MODE_PASS) && !is_protected;
  assign trigger        = eligible && (lfsr_q[7:0] < i_corrupt_thresh);
  assign flip_idx       = lfsr_q[8 +: BIT_W];
  assign burst_rem_load = (i_burst_len == 4'd0) ? 4'd0 : i_burst_len - 4'd1;

  // One-hot mask selecting the bit to invert in single-bit flip mode
  always_comb begin
    flip_mask           = '0;
    flip_mask[flip_idx] = 1'b1;
  end

  // Next word, FSM transition and counter update. The trigger word of a
  // burst is corrupted from IDLE; "remaining" then counts the further words
  // to invert, and the burst ends on the first eligible word that finds it
  // exhausted (that word passes clean).
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    data_d    = line.i_frame_data;
    corrupt   = 1'b0;
    err_cnt_d = err_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          unique case (mode)
            MODE_REPLACE: begin
              data_d  = '1;
              corrupt = 1'b1;
            end
            MODE_FLIP: begin
              data_d  = line.i_frame_data ^ flip_mask;
              corrupt = 1'b1;
            end
            MODE_BURST: begin
              data_d  = ~line.i_frame_data;
              corrupt = 1'b1;
              state_d = ST_BURST;
              rem_d   = burst_rem_load;
            end
            default: begin
              data_d = line.i_frame_data;
            end
          endcase
        end
      end
      ST_BURST: begin
        if (!i_corrupt_en || (mode != MODE_BURST)) begin
          state_d = ST_IDLE;
          rem_d   = 4'd0;
        end else if (eligible) begin
          if (rem_q == 4'd0) begin
            state_d = ST_IDLE;
          end else begin
            data_d  = ~line.i_frame_data;
            corrupt = 1'b1;
            rem_d   = rem_q - 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        rem_d   = 4'd0;
      end
    endcase
    if (i_cnt_clr) begin
      err_cnt_d = '0;
    end else if (corrupt && (err_cnt_q != 32'hFFFF_FFFF)) begin
      err_cnt_d = err_cnt_q + 32'd1;
    end
  end

  // Register the FSM, the outgoing word and the error counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      rem_q     <= 4'd0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      fas_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      data_q    <= data_d;
      valid_q   <= line.i_frame_data_valid;
      fas_q     <= line.i_frame_data_fas;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign line.o_frame_data       = data_q;
  assign line.o_frame_data_valid = valid_q;
  assign line.o_frame_data_fas   = fas_q;
  assign o_err_cnt               = err_cnt_q;
  assign o_burst_active          = (state_q == ST_BURST);

endmodule

// File: doc/err_injector.md
ERR_INJECTOR -- requirements
Module: err_injector

Interface
REQ-001 Parameter DATA_W, default 8, frame word width; SHALL be a power of two, 8..64.
REQ-002 Parameter LFSR_W, default 16, LFSR width; SHALL be at least 8 + log2(DATA_W).
REQ-003 Parameter PROT_COLS, default 7, count of protected columns in row 0.
REQ-004 i_clk  in  1  sole clock; all logic on the rising edge.
REQ-005 i_rst  in  1  reset, asynchronous, active-high.
REQ-006 i_row_cnt  in  2  frame row index.
REQ-007 i_col_cnt  in  11  frame column index.
REQ-008 i_frame_data / i_frame_data_valid / i_frame_data_fas  in  DATA_W/1/1  line input.
REQ-009 o_frame_data / o_frame_data_valid / o_frame_data_fas  out  DATA_W/1/1  line output, registered.
REQ-010 i_corrupt_en  in  1  master enable.
REQ-011 i_corrupt_mode  in  2  0 pass, 1 word-replace, 2 single-bit flip, 3 burst.
REQ-012 i_corrupt_seed  in  LFSR_W  LFSR seed, loaded at reset.
REQ-013 i_corrupt_thresh  in  8  trigger probability, thresh/256 per eligible word.
REQ-014 i_burst_len  in  4  words per burst, 0 treated as 1.
REQ-015 i_cnt_clr  in  1  synchronous clear of o_err_cnt.
REQ-016 o_err_cnt  out  32  saturating count of corrupted words.
REQ-017 o_burst_active  out  1  high while the FSM is in BURST.

Function
REQ-018 Latency SHALL be exactly 1 cycle: valid and fas pass unchanged, and data is modified only as specified below.
REQ-019 Eligible word: i_frame_data_valid=1, i_corrupt_en=1, mode!=0, and NOT (i_row_cnt=0 and i_col_cnt<PROT_COLS).
REQ-020 Protected or non-eligible words SHALL pass unmodified and SHALL NOT consume burst count.
REQ-021 The LFSR SHALL advance one step per cycle with i_corrupt_en=1 and i_frame_data_valid=1, protected words included, and SHALL hold otherwise.
REQ-022 Trigger = eligible AND LFSR[7:0] < i_corrupt_thresh; thresh=0 never triggers.
REQ-023 Mode 1: a triggered word SHALL be output as all-ones.
REQ-024 Mode 2: a triggered word SHALL have bit LFSR[8+log2(DATA_W)-1:8] inverted.
REQ-025 FSM states IDLE and BURST; IDLE->BURST on a mode-3 trigger, loading remaining=max(i_burst_len,1)-1; that trigger word is corrupted.
REQ-026 In BURST each eligible word SHALL be bitwise inverted and decrement remaining; when remaining=0 on an eligible word, the FSM SHALL return to IDLE after that word.
REQ-027 BURST SHALL exit to IDLE on the next edge if i_corrupt_en=0 or mode!=3; that cycle's word is not corrupted.
REQ-028 A burst of length 1 SHALL enter BURST with remaining=0 and return to IDLE on the next eligible word.
REQ-029 o_err_cnt SHALL increment by 1 per corrupted word, saturate at 0xFFFFFFFF, and be zeroed by i_cnt_clr, which wins over a same-cycle increment.
REQ-030 A mode change while in IDLE SHALL take effect on the next word without a glitch.

Reset
REQ-031 On i_rst: o_frame_data=0, o_frame_data_valid=0, o_frame_data_fas=0, o_err_cnt=0, o_burst_active=0, FSM=IDLE, remaining=0.
REQ-032 On i_rst the LFSR SHALL load i_corrupt_seed, or 1 if the seed is all-zero.
REQ-033 Reset asserted mid-burst SHALL abort the burst immediately; no corrupted word is output after reset assertion.

Structure
REQ-034 Package err_inj_pkg SHALL hold the mode encodings, the FSM state type, and the LFSR tap constants for LFSR_W 8/16/32 (x^16+x^14+x^13+x^11+1 for 16).
REQ-035 The LFSR SHALL be a sub-module err_lfsr with ports clk, rst, seed, step, state.

Verification
REQ-036 mode=0, en=1, 1000 random words -> output equals input delayed 1 cycle; o_err_cnt=0.
REQ-037 mode=1, thresh=255, row0 cols 0..10 -> cols 0..6 unchanged, cols 7..10 = 0xFF, o_err_cnt=4.
REQ-038 mode=3, burst_len=3, thresh=255, then thresh=0 after the trigger -> exactly 3 eligible words inverted (0x5A->0xA5); o_burst_active high 3 cycles; o_err_cnt=3.
REQ-039 BURST active with remaining=5, drop en -> next word passes unchanged; FSM=IDLE; o_err_cnt stops.
REQ-040 seed=0, mode=2, thresh=128 -> LFSR nonzero; each corrupted word differs from the input in exactly 1 bit; counts match the reference model.
REQ-041 preload o_err_cnt near 0xFFFFFFFE, 3 triggers -> saturates at 0xFFFFFFFF; i_cnt_clr with a same-cycle trigger -> 0.
